seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the multi-digit seven-segment display.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_scan_ctrl_if.sv | 26 ++
 rtl/seg_hex_decode.sv | 12 +
 rtl/seg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the scan state enum, the active-high hex glyph table and the dark pattern.
package seg_pkg;

  typedef enum logic {
    BLANK,
    ON
  } state_t;

  // {dp,g,f,e,d,c,b,a}, active-high
  localparam logic [7:0] SEG_OFF = 8'h00;

  // gfedcba glyphs for 0-F, active-high
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host write port of the scan controller: valid/ready digit-code writes.
// master: wr_valid, wr_addr, wr_data out, wr_ready in; slave: the reverse.
interface seg_scan_ctrl_if #(
  parameter int AW = 2
) ();

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [5:0]    wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex to 7-segment glyph decoder.
// Ports: hex in (4), pat out (7, gfedcba, active-high).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] pat
);

  assign pat = SEG_HEX[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with shadow buffer and blank gap.
// Ports: clock, reset_n, wr (slave), clear, brightness (SEG_DIM_EN only),
//        seg, digit_sel, frame_tick. Optional PWM dimming under SEG_DIM_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  seg_scan_ctrl_if.slave        wr,
  input  logic                  clear,
`ifdef SEG_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_tick
);

  localparam int AW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic POL = (ACTIVE_LOW != 0);

  state_t          state;
  logic [AW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic [5:0]      shadow [NUM_DIGITS];
  logic [5:0]      active [NUM_DIGITS];

  logic            accept;
  logic            in_range;
  logic            blank_end;
  logic            slot_end;
  logic            last;
  logic            commit;

  assign wr.wr_ready = reset_n & ~clear;
  assign accept      = wr.wr_valid & wr.wr_ready;
  assign in_range    =
    {1'b0, wr.wr_addr} < (AW + 1)'(NUM_DIGITS);

  assign blank_end =
    (state == BLANK) && (cnt == CW'(BLANK_CYCLES - 1));
  assign slot_end  =
    (state == ON) && (cnt == CW'(SLOT_CYCLES - 1));
  assign last      = (idx == AW'(NUM_DIGITS - 1));
  assign commit    = slot_end & last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BLANK;
      idx        <= '0;
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= commit;
      unique case (1'b1)
        blank_end: begin
          state <= ON;
          cnt   <= cnt + CW'(1);
        end
        slot_end: begin
          state <= BLANK;
          cnt   <= '0;
          idx   <= last ? '0 : idx + AW'(1);
        end
        default: cnt <= cnt + CW'(1);
      endcase
    end
  end

  // A write landing on the commit edge must reach active directly,
  // otherwise it would wait a whole extra frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (accept && in_range)
        shadow[wr.wr_addr] <= wr.wr_data;
      if (commit) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          active[i] <= shadow[i];
        if (accept && in_range)
          active[wr.wr_addr] <= wr.wr_data;
      end
    end
  end

  logic lit;

`ifdef SEG_DIM_EN
  logic [3:0] pwm;
  logic [3:0] bright_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm      <= '0;
      bright_q <= '0;
    end else if (blank_end) begin
      pwm      <= '0;
      bright_q <= brightness;
    end else if (state == ON) begin
      pwm <= pwm + 4'd1;
    end
  end

  assign lit = (pwm < bright_q);
`else
  assign lit = 1'b1;
`endif

  logic [5:0]            cur;
  logic [6:0]            pat;
  logic                  drive;
  logic [7:0]            seg_n;
  logic [NUM_DIGITS-1:0] sel_n;

  assign cur   = active[idx];
  assign drive = (state == ON) & cur[5] & lit;

  seg_hex_decode u_dec (
    .hex (cur[3:0]),
    .pat (pat)
  );

  always_comb begin
    sel_n      = '0;
    sel_n[idx] = drive;
    seg_n      = drive ? {cur[4], pat} : SEG_OFF;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg       <= SEG_OFF ^ {8{POL}};
      digit_sel <= {NUM_DIGITS{POL}};
    end else begin
      seg       <= seg_n ^ {8{POL}};
      digit_sel <= sel_n ^ {NUM_DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame scoreboard of expected digit contents.
// NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2, ACTIVE_LOW=1; dimming frames with SEG_DIM_EN.
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [3:0][5:0] d;
    logic [4:0]      br;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] seg;
  logic [3:0] digit_sel;
  logic       frame_tick;
`ifdef SEG_DIM_EN
  logic [3:0] brightness = 4'd15;
`endif

  int checks = 0;
  int errors = 0;

  frame_t q[$];

  seg_scan_ctrl_if #(.AW(2)) wr_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SLOT_CYCLES  (8),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr         (wr_if),
    .clear      (clear),
`ifdef SEG_DIM_EN
    .brightness (brightness),
`endif
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  function automatic frame_t mk(
    input logic [5:0] d3,
    input logic [5:0] d2,
    input logic [5:0] d1,
    input logic [5:0] d0,
    input int         br
  );
    frame_t f;
    f.d  = {d3, d2, d1, d0};
    f.br = br[4:0];
    return f;
  endfunction

  // Checks one 32-cycle frame starting right after a frame_tick
  // (or reset release); optionally drives one write/clear at
  // frame-local sample wr_at.
  task automatic capture(
    input int         wr_at,
    input logic [1:0] wa,
    input logic [5:0] wd,
    input logic       clr
  );
    frame_t     f;
    int         s;
    int         c;
    logic [5:0] dg;
    logic       on;
    logic [3:0] one;
    logic [7:0] e_seg;
    logic [3:0] e_sel;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    f   = q.pop_front();
    one = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      s  = k / 8;
      c  = k % 8;
      dg = f.d[s];
      on = (c >= 2) && dg[5] && ((c - 2) < int'(f.br));
      e_seg = on ? ~{dg[4], hex7(dg[3:0])} : 8'hFF;
      e_sel = on ? ~(one << s) : 4'hF;
      chk($sformatf("seg s%0d c%0d", s, c), seg, e_seg);
      chk($sformatf("sel s%0d c%0d", s, c), digit_sel, e_sel);
      chk($sformatf("tick k%0d", k), frame_tick, (k == 31));
      if (k == wr_at) begin
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = wa;
        wr_if.wr_data  = wd;
        clear          = clr;
        #1;
        chk("wr_ready", wr_if.wr_ready, !clr);
      end else if (k == wr_at + 1) begin
        wr_if.wr_valid = 1'b0;
        clear          = 1'b0;
      end
    end
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;

    repeat (3) @(negedge clock);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_sel", digit_sel, 4'hF);
    chk("rst_tick", frame_tick, 1'b0);
    chk("rst_rdy", wr_if.wr_ready, 1'b0);
    reset_n = 1'b1;

    // frame 0 dark; write digit 1 = '5' mid-frame
    q.push_back(mk(6'h00, 6'h00, 6'h00, 6'h00, 16));
    q.push_back(mk(6'h00, 6'h00, 6'h25, 6'h00, 16));
    capture(3, 2'd1, 6'h25, 1'b0);

    // frame 1 shows digit 1; write digit 3 on commit edge
    q.push_back(mk(6'h38, 6'h00, 6'h25, 6'h00, 16));
    capture(30, 2'd3, 6'h38, 1'b0);

    // frame 2 shows both; clear + write on commit edge
    q.push_back(mk(6'h00, 6'h00, 6'h00, 6'h00, 16));
    capture(30, 2'd0, 6'h1A, 1'b1);

    // frame 3 dark; write digit 0 = 'A'
    q.push_back(mk(6'h00, 6'h00, 6'h00, 6'h2A, 16));
    capture(5, 2'd0, 6'h2A, 1'b0);

    // frame 4 shows digit 0 only
    capture(-1, 2'd0, 6'h00, 1'b0);

`ifdef SEG_DIM_EN
    brightness = 4'd4;
    q.push_back(mk(6'h00, 6'h00, 6'h00, 6'h2A, 4));
    capture(-1, 2'd0, 6'h00, 1'b0);
    brightness = 4'd0;
    q.push_back(mk(6'h00, 6'h00, 6'h00, 6'h2A, 0));
    capture(-1, 2'd0, 6'h00, 1'b0);
    brightness = 4'd15;
`endif

    // reset in the middle of slot 0 ON phase
    repeat (4) @(negedge clock);
    chk("pre_rst_seg", seg, 8'h88);
    chk("pre_rst_sel", digit_sel, 4'hE);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_seg", seg, 8'hFF);
    chk("mid_rst_sel", digit_sel, 4'hF);
    chk("mid_rst_rdy", wr_if.wr_ready, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    q.push_back(mk(6'h00, 6'h00, 6'h00, 6'h00, 16));
    capture(-1, 2'd0, 6'h00, 1'b0);

    chk("sb_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
